// File: rtl/exmem_loader.sv
// Program loader and port arbiter in front of the external byte memory.
// Streams an image into memory, reads it back to check a byte checksum, then releases the CPU.
module exmem_loader #(
  parameter int WIDTH         = 8,
  parameter int RAM_ADDR_BITS = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [RAM_ADDR_BITS:0]   len,
  input  logic                     in_valid,
  input  logic [WIDTH-1:0]         in_data,
  output logic                     in_ready,
  input  logic                     cpu_en,
  input  logic                     cpu_memwrite,
  input  logic [RAM_ADDR_BITS-1:0] cpu_adr,
  input  logic [WIDTH-1:0]         cpu_writedata,
  output logic                     mem_en,
  output logic                     mem_memwrite,
  output logic [RAM_ADDR_BITS-1:0] mem_adr,
  output logic [WIDTH-1:0]         mem_writedata,
  input  logic [WIDTH-1:0]         mem_memdata,
  output logic                     cpu_reset,
  output logic                     busy,
  output logic                     done,
  output logic                     err,
  output logic [WIDTH-1:0]         checksum
);

  localparam logic [RAM_ADDR_BITS:0]   DEPTH    = {1'b1, {RAM_ADDR_BITS{1'b0}}};
  localparam logic [RAM_ADDR_BITS:0]   CNT_ONE  = {{RAM_ADDR_BITS{1'b0}}, 1'b1};
  localparam logic [RAM_ADDR_BITS-1:0] ADDR_ONE = {{(RAM_ADDR_BITS-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, LOAD, VERIFY, DONE} state_t;

  state_t                   state;
  state_t                   state_next;
  logic [RAM_ADDR_BITS:0]   len_q;
  logic [RAM_ADDR_BITS:0]   len_sat;
  logic [RAM_ADDR_BITS:0]   count;
  logic [RAM_ADDR_BITS:0]   rd_count;
  logic [RAM_ADDR_BITS-1:0] wr_addr;
  logic [RAM_ADDR_BITS-1:0] rd_addr;
  logic [WIDTH-1:0]         rd_sum;
  logic                     rd_valid;
  logic                     xfer;
  logic                     load_last;
  logic                     rd_last;

  // Anything longer than the memory is clipped to one full pass over it.
  assign len_sat   = (len > DEPTH) ? DEPTH : len;
  assign xfer      = (state == LOAD) && in_valid;
  assign load_last = xfer && ((count + CNT_ONE) == len_q);
  assign rd_last   = rd_valid && ((rd_count + CNT_ONE) == len_q);
  assign cpu_reset = reset | busy;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next    = state;
    in_ready      = 1'b0;
    busy          = 1'b1;
    done          = 1'b0;
    mem_en        = cpu_en;
    mem_memwrite  = cpu_memwrite;
    mem_adr       = cpu_adr;
    mem_writedata = cpu_writedata;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_next = (len_sat == '0) ? DONE : LOAD;
      end
      LOAD: begin
        in_ready      = 1'b1;
        mem_en        = in_valid;
        mem_memwrite  = in_valid;
        mem_adr       = wr_addr;
        mem_writedata = in_data;
        if (load_last) state_next = VERIFY;
      end
      VERIFY: begin
        mem_en        = 1'b1;
        mem_memwrite  = 1'b0;
        mem_adr       = rd_addr;
        mem_writedata = '0;
        if (!rd_valid) state_next = DONE;
      end
      DONE: begin
        mem_en        = 1'b0;
        mem_memwrite  = 1'b0;
        done          = 1'b1;
        state_next    = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // rd_valid means the byte for rd_addr will sit on mem_memdata at the coming edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      len_q    <= '0;
      count    <= '0;
      rd_count <= '0;
      wr_addr  <= '0;
      rd_addr  <= '0;
      checksum <= '0;
      rd_sum   <= '0;
      rd_valid <= 1'b0;
      err      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            len_q    <= len_sat;
            count    <= '0;
            rd_count <= '0;
            wr_addr  <= '0;
            rd_addr  <= '0;
            checksum <= '0;
            rd_sum   <= '0;
            rd_valid <= 1'b0;
            err      <= 1'b0;
          end
        end
        LOAD: begin
          if (xfer) begin
            wr_addr  <= wr_addr + ADDR_ONE;
            checksum <= checksum + in_data;
            count    <= count + CNT_ONE;
            if (load_last) rd_valid <= 1'b1;
          end
        end
        VERIFY: begin
          if (rd_valid) begin
            rd_addr  <= rd_addr + ADDR_ONE;
            rd_sum   <= rd_sum + mem_memdata;
            rd_count <= rd_count + CNT_ONE;
            if (rd_last) rd_valid <= 1'b0;
          end else begin
            err <= (rd_sum != checksum);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_exmem_loader.sv
// Self-checking bench for exmem_loader: table of load images plus hand-written reset sequences.
module tb_exmem_loader;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [8:0] len;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       cpu_en;
  logic       cpu_memwrite;
  logic [7:0] cpu_adr;
  logic [7:0] cpu_writedata;
  logic       mem_en;
  logic       mem_memwrite;
  logic [7:0] mem_adr;
  logic [7:0] mem_writedata;
  logic [7:0] mem_memdata;
  logic       cpu_reset;
  logic       busy;
  logic       done;
  logic       err;
  logic [7:0] checksum;

  logic [7:0] mem [256];
  logic       corrupt_req;
  logic [7:0] model [256];
  bit         known [256];

  int checks = 0;
  int passes = 0;

  typedef struct {
    logic [8:0]      len;
    logic [3:0][7:0] data;
    int              gap;
    bit              corrupt;
    bit              midstart;
    bit              ramp;
    logic [7:0]      xorv;
    logic [7:0]      exp_sum;
    bit              exp_err;
    int              exp_cycles;
  } vec_t;

  vec_t vecs [10];

  exmem_loader #(.WIDTH(8), .RAM_ADDR_BITS(8)) dut (
    .clk(clk), .reset(reset), .start(start), .len(len),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .cpu_en(cpu_en), .cpu_memwrite(cpu_memwrite), .cpu_adr(cpu_adr),
    .cpu_writedata(cpu_writedata), .mem_en(mem_en), .mem_memwrite(mem_memwrite),
    .mem_adr(mem_adr), .mem_writedata(mem_writedata), .mem_memdata(mem_memdata),
    .cpu_reset(cpu_reset), .busy(busy), .done(done), .err(err), .checksum(checksum)
  );

  always #5 clk = ~clk;

  // Byte memory sampling on the falling edge; corrupt_req plants a bad byte at address 2.
  always @(negedge clk) begin
    if (corrupt_req) mem[2] <= 8'hEE;
    if (mem_en) begin
      if (mem_memwrite) mem[mem_adr] <= mem_writedata;
      else              mem_memdata  <= mem[mem_adr];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic vec_t mk(input logic [8:0] l, input logic [31:0] d, input int gap,
                              input bit corrupt, input bit midstart, input bit ramp,
                              input logic [7:0] xorv, input logic [7:0] sum, input bit e,
                              input int cyc);
    vec_t v;
    v.len = l; v.data = d; v.gap = gap; v.corrupt = corrupt; v.midstart = midstart;
    v.ramp = ramp; v.xorv = xorv; v.exp_sum = sum; v.exp_err = e; v.exp_cycles = cyc;
    return v;
  endfunction

  function automatic int sat_len(input logic [8:0] l);
    return (l > 9'd256) ? 256 : int'(l);
  endfunction

  function automatic logic [7:0] byte_for(input vec_t v, input int idx);
    if (v.ramp) return 8'(idx) ^ v.xorv;
    return v.data[idx & 3];
  endfunction

  // Drives one start/load sequence; returns cycles from the start edge until done is seen.
  task automatic apply_stimulus(input vec_t v, output int cycles, output bit held);
    int idx;
    int idle;
    int limit;
    int n;
    bit xfer;
    idx = 0; idle = 0; cycles = 0; held = 1'b1;
    limit = v.exp_cycles + 20;
    n = sat_len(v.len);
    start = 1'b1;
    len = v.len;
    while (1) begin
      if (idx < n && idle == 0) begin
        in_valid = 1'b1;
        in_data  = byte_for(v, idx);
      end else begin
        in_valid = 1'b0;
      end
      xfer = in_valid && in_ready;
      @(posedge clk);
      #1;
      cycles++;
      start = 1'b0;
      if (v.midstart && cycles == 2) begin
        start = 1'b1;
        len   = 9'd1;
      end
      corrupt_req   = v.corrupt && (cycles == 5);
      cpu_en        = (cycles >= 2);
      cpu_memwrite  = 1'b1;
      cpu_adr       = 8'h40;
      cpu_writedata = 8'h99;
      if (xfer) begin
        idx++;
        idle = v.gap;
      end else if (idle > 0) begin
        idle--;
      end
      if (!cpu_reset) held = 1'b0;
      if (done || cycles >= limit) break;
    end
    in_valid    = 1'b0;
    cpu_en      = 1'b0;
    corrupt_req = 1'b0;
    start       = 1'b0;
  endtask

  task automatic check_output(input vec_t v, input int cycles, input bit held, input int k);
    int n;
    int bad;
    int first;
    check($sformatf("v%0d latency", k), cycles, v.exp_cycles);
    check($sformatf("v%0d checksum", k), checksum, v.exp_sum);
    check($sformatf("v%0d err", k), err, v.exp_err);
    check($sformatf("v%0d cpu_reset_held", k), held, 1);
    n = sat_len(v.len);
    for (int i = 0; i < n; i++) begin
      model[i] = byte_for(v, i);
      known[i] = 1'b1;
    end
    if (v.corrupt) model[2] = 8'hEE;
    bad = 0; first = 0;
    for (int i = 0; i < 256; i++) begin
      if (known[i] && mem[i] !== model[i]) begin
        if (bad == 0) first = i;
        bad++;
      end
    end
    checks++;
    if (bad == 0) passes++;
    else $display("[TB] FAIL v%0d mem_image: %0d bad bytes, mem[0x%0h]=0x%0h, expected 0x%0h",
                  k, bad, first, mem[first], model[first]);
    @(posedge clk);
    #1;
    check($sformatf("v%0d done_one_cycle", k), {done, busy}, 2'b00);
    if (cycles != v.exp_cycles) begin
      reset = 1'b1;
      #1;
      reset = 1'b0;
    end
  endtask

  initial begin
    int cycles;
    bit held;
    reset = 1'b1; start = 1'b0; len = '0; in_valid = 1'b0; in_data = '0;
    cpu_en = 1'b0; cpu_memwrite = 1'b0; cpu_adr = 8'h5C; cpu_writedata = 8'h00;
    corrupt_req = 1'b0;

    vecs[0] = mk(9'd4,   32'h05000820, 0, 0, 0, 0, 8'h00, 8'h2D, 0, 10);
    vecs[1] = mk(9'd4,   32'h05000820, 2, 0, 0, 0, 8'h00, 8'h2D, 0, 16);
    vecs[2] = mk(9'd3,   32'h00332211, 0, 0, 1, 0, 8'h00, 8'h66, 0, 8);
    vecs[3] = mk(9'd2,   32'h000002FF, 1, 0, 0, 0, 8'h00, 8'h01, 0, 7);
    vecs[4] = mk(9'd1,   32'h000000A5, 0, 0, 0, 0, 8'h00, 8'hA5, 0, 4);
    vecs[5] = mk(9'd0,   32'h00000000, 0, 0, 0, 0, 8'h00, 8'h00, 0, 1);
    vecs[6] = mk(9'd4,   32'h05000820, 0, 1, 0, 0, 8'h00, 8'h2D, 1, 10);
    vecs[7] = mk(9'd0,   32'h00000000, 0, 0, 0, 0, 8'h00, 8'h00, 0, 1);
    vecs[8] = mk(9'd256, 32'h00000000, 0, 0, 0, 1, 8'h00, 8'h80, 0, 514);
    vecs[9] = mk(9'h1FF, 32'h00000000, 0, 0, 0, 1, 8'h3C, 8'h80, 0, 514);

    #12;
    check("rst busy", busy, 0);
    check("rst done", done, 0);
    check("rst err", err, 0);
    check("rst checksum", checksum, 0);
    check("rst in_ready", in_ready, 0);
    check("rst cpu_reset", cpu_reset, 1);
    check("rst mem_adr passthrough", mem_adr, 8'h5C);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("idle cpu_reset", cpu_reset, 0);
    cpu_en = 1'b1; cpu_memwrite = 1'b1; cpu_adr = 8'h40; cpu_writedata = 8'h3C;
    @(posedge clk);
    #1;
    cpu_en = 1'b0;
    check("cpu write 0x40", mem[8'h40], 8'h3C);
    model[8'h40] = 8'h3C;
    known[8'h40] = 1'b1;

    for (int k = 0; k < 10; k++) begin
      apply_stimulus(vecs[k], cycles, held);
      check_output(vecs[k], cycles, held, k);
    end

    // Reset mid-load: two of four bytes in, then an asynchronous reset between edges.
    cpu_en = 1'b0; cpu_adr = 8'h10;
    start = 1'b1; len = 9'd4;
    @(posedge clk); #1;
    start = 1'b0; in_valid = 1'b1; in_data = 8'h77;
    @(posedge clk); #1;
    in_data = 8'h88;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("midload checksum", checksum, 8'hFF);
    check("midload busy", busy, 1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("async busy", busy, 0);
    check("async checksum", checksum, 0);
    check("async in_ready", in_ready, 0);
    check("async cpu_reset", cpu_reset, 1);
    check("async done", done, 0);
    check("async mem_adr passthrough", mem_adr, 8'h10);
    #2;
    reset = 1'b0;
    @(posedge clk); #1;
    cpu_en = 1'b1; cpu_memwrite = 1'b1; cpu_adr = 8'h10; cpu_writedata = 8'hAA;
    @(posedge clk); #1;
    cpu_en = 1'b0;
    check("post-reset cpu write", mem[8'h10], 8'hAA);
    check("persist mem[0]", mem[0], 8'h77);
    check("persist mem[1]", mem[1], 8'h88);
    check("post-reset busy", busy, 0);
    check("post-reset cpu_reset", cpu_reset, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
